// File: rtl/mem_axi_bridge_pkg.sv
// Shared types and AXI constants for the line-to-AXI4 burst bridge.
package mem_axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_BRESP,
      RESP,
      GAP
   } mab_state_e;

   localparam int         BEATS      = 4;
   localparam logic [2:0] AXSIZE_8B  = 3'b011;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/mem_axi_bridge.sv
// Turns one 256-bit line fill / write-back into a 4-beat INCR AXI4 burst,
// one transaction at a time, with a sticky protocol/response error flag.
module mem_axi_bridge
   import mem_axi_pkg::*;
#(
   parameter int         LINE_W = 256,
   parameter int         AXI_DW = 64,
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mem_req_valid,
   input  logic [31:0]         mem_req_addr,
   input  logic                mem_req_we,
   input  logic [LINE_W-1:0]   mem_req_data,
   output logic                mem_resp_valid,
   output logic [LINE_W-1:0]   mem_resp_data,
   output logic                axi_arvalid,
   input  logic                axi_arready,
   output logic [3:0]          axi_arid,
   output logic [31:0]         axi_araddr,
   output logic [7:0]          axi_arlen,
   output logic [2:0]          axi_arsize,
   output logic [1:0]          axi_arburst,
   input  logic                axi_rvalid,
   output logic                axi_rready,
   input  logic [AXI_DW-1:0]   axi_rdata,
   input  logic [1:0]          axi_rresp,
   input  logic                axi_rlast,
   output logic                axi_awvalid,
   input  logic                axi_awready,
   output logic [3:0]          axi_awid,
   output logic [31:0]         axi_awaddr,
   output logic [7:0]          axi_awlen,
   output logic [2:0]          axi_awsize,
   output logic [1:0]          axi_awburst,
   output logic                axi_wvalid,
   input  logic                axi_wready,
   output logic [AXI_DW-1:0]   axi_wdata,
   output logic [AXI_DW/8-1:0] axi_wstrb,
   output logic                axi_wlast,
   input  logic                axi_bvalid,
   output logic                axi_bready,
   input  logic [1:0]          axi_bresp,
   output logic                bus_err
);

   localparam logic [1:0]  LAST_BEAT = 2'(BEATS - 1);
   localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

   mab_state_e          state_q, state_d;
   logic [1:0]          beat_q, beat_d;
   logic [31:0]         addr_q, addr_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                arvalid_q, arvalid_d, rready_q, rready_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic                wlast_q, wlast_d, bready_q, bready_d;
   logic                resp_valid_q, resp_valid_d;
   logic [LINE_W-1:0]   resp_data_q, resp_data_d;
   logic                bus_err_q, bus_err_d;

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      addr_d       = addr_q;
      line_d       = line_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      wlast_d      = wlast_q;
      bready_d     = bready_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      bus_err_d    = bus_err_q;
      unique case (state_q)
         IDLE: if (mem_req_valid) begin
            addr_d    = mem_req_addr & ADDR_MASK;
            line_d    = mem_req_data;
            beat_d    = '0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (mem_req_we) begin
               state_d   = WR_ADDR;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end else begin
               state_d   = RD_ADDR;
               arvalid_d = 1'b1;
            end
         end
         RD_ADDR: if (axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = RD_DATA;
         end
         RD_DATA: if (axi_rvalid) begin
            line_d[int'(beat_q)*AXI_DW +: AXI_DW] = axi_rdata;
            // rlast must appear on exactly the final beat; the burst still runs 4 beats
            if (axi_rresp != RESP_OKAY || axi_rlast != (beat_q == LAST_BEAT))
               bus_err_d = 1'b1;
            beat_d = beat_q + 2'd1;
            if (beat_q == LAST_BEAT) begin
               rready_d     = 1'b0;
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = line_d;
            end
         end
         WR_ADDR: begin
            if (awvalid_q && axi_awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && axi_wready) begin
               beat_d  = beat_q + 2'd1;
               wlast_d = (beat_q == LAST_BEAT - 2'd1);
               if (beat_q == LAST_BEAT) begin
                  wvalid_d = 1'b0;
                  w_done_d = 1'b1;
               end
            end
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = WR_BRESP;
            end
         end
         WR_BRESP: if (axi_bvalid) begin
            if (axi_bresp != RESP_OKAY) bus_err_d = 1'b1;
            bready_d     = 1'b0;
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
         end
         RESP:    state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         addr_q       <= '0;
         line_q       <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         wlast_q      <= 1'b0;
         bready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         addr_q       <= addr_d;
         line_q       <= line_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         wlast_q      <= wlast_d;
         bready_q     <= bready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign mem_resp_valid = resp_valid_q;
   assign mem_resp_data  = resp_data_q;
   assign bus_err        = bus_err_q;

   assign axi_arvalid = arvalid_q;
   assign axi_arid    = AXI_ID;
   assign axi_araddr  = addr_q;
   assign axi_arlen   = 8'(BEATS - 1);
   assign axi_arsize  = AXSIZE_8B;
   assign axi_arburst = BURST_INCR;
   assign axi_rready  = rready_q;

   assign axi_awvalid = awvalid_q;
   assign axi_awid    = AXI_ID;
   assign axi_awaddr  = addr_q;
   assign axi_awlen   = 8'(BEATS - 1);
   assign axi_awsize  = AXSIZE_8B;
   assign axi_awburst = BURST_INCR;
   assign axi_wvalid  = wvalid_q;
   assign axi_wdata   = line_q[int'(beat_q)*AXI_DW +: AXI_DW];
   assign axi_wstrb   = '1;
   assign axi_wlast   = wlast_q;
   assign axi_bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Line-request driver, scoreboarded responses, and a reactive AXI slave with stall knobs.
module tb_mem_axi_bridge;

   logic         clock, reset;
   logic         mem_req_valid, mem_req_we;
   logic [31:0]  mem_req_addr;
   logic [255:0] mem_req_data;
   logic         mem_resp_valid;
   logic [255:0] mem_resp_data;
   logic         axi_arvalid, axi_arready;
   logic [3:0]   axi_arid, axi_awid;
   logic [31:0]  axi_araddr, axi_awaddr;
   logic [7:0]   axi_arlen, axi_awlen;
   logic [2:0]   axi_arsize, axi_awsize;
   logic [1:0]   axi_arburst, axi_awburst;
   logic         axi_rvalid, axi_rready, axi_rlast;
   logic [63:0]  axi_rdata, axi_wdata;
   logic [1:0]   axi_rresp, axi_bresp;
   logic         axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
   logic [7:0]   axi_wstrb;
   logic         axi_bvalid, axi_bready, bus_err;

   mem_axi_bridge dut (
      .clock(clock), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
      .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
      .bus_err(bus_err)
   );

   int n_run, n_fail;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc;
   initial begin
      cyc = 0;
      forever @(posedge clock) cyc++;
   end

   // slave knobs and shared transaction context
   logic [255:0] cur_line;
   logic [31:0]  cur_addr;
   bit           rnd_mode;
   int           aw_delay, rlast_bad;
   logic [1:0]   bresp_inj;

   int  r_beat, w_beat, r_owed, r_total, ar_cnt, aw_wait;
   bit  aw_got, w_got, b_pend, ar_stall, w_stall, hs_r, hs_b;
   int  t_aw, t_w3, t_b, t_resp;
   logic [31:0] ar_prev;
   logic [64:0] w_prev;

   function automatic logic coin();
      return 1'($urandom_range(0, 1));
   endfunction

   initial begin
      axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 0;
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0;
      r_beat = 0; w_beat = 0; r_owed = 0; r_total = 0; ar_cnt = 0; aw_wait = 0;
      aw_got = 0; w_got = 0; b_pend = 0; ar_stall = 0; w_stall = 0;
      t_aw = 0; t_w3 = 0; t_b = 0; ar_prev = '0; w_prev = '0;
      forever begin
         @(negedge clock);
         hs_r = axi_rvalid && axi_rready;
         hs_b = axi_bvalid && axi_bready;
         if (!reset) begin
            r_beat = 0; w_beat = 0; r_owed = 0; aw_wait = 0;
            aw_got = 0; w_got = 0; b_pend = 0; ar_stall = 0; w_stall = 0;
         end else begin
            if (ar_stall) chk("ar_stable", {axi_arvalid, axi_araddr}, {1'b1, ar_prev});
            if (w_stall)  chk("w_stable", {axi_wvalid, axi_wlast, axi_wdata}, {1'b1, w_prev});
            ar_stall = axi_arvalid && !axi_arready;
            ar_prev  = axi_araddr;
            w_stall  = axi_wvalid && !axi_wready;
            w_prev   = {axi_wlast, axi_wdata};
            if (axi_arvalid && axi_arready) begin
               ar_cnt++;
               r_owed += 4;
               chk("araddr", axi_araddr, cur_addr);
               chk("ar_fields", {axi_arid, axi_arlen, axi_arsize, axi_arburst}, {4'd0, 8'd3, 3'b011, 2'b01});
            end
            if (hs_r) begin
               r_beat = (r_beat + 1) % 4;
               r_owed--;
               r_total++;
            end
            if (axi_awvalid && axi_awready) begin
               aw_got = 1; t_aw = cyc; aw_wait = 0;
               chk("awaddr", axi_awaddr, cur_addr);
               chk("aw_fields", {axi_awid, axi_awlen, axi_awsize, axi_awburst}, {4'd0, 8'd3, 3'b011, 2'b01});
            end else if (axi_awvalid) aw_wait++;
            if (axi_wvalid && axi_wready) begin
               chk("wdata", axi_wdata, cur_line[w_beat*64 +: 64]);
               chk("wlast", axi_wlast, w_beat == 3);
               chk("wstrb", axi_wstrb, 8'hFF);
               if (w_beat == 3) begin w_got = 1; t_w3 = cyc; end
               w_beat = (w_beat + 1) % 4;
            end
            if (hs_b) begin b_pend = 0; t_b = cyc; end
            if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
         end
         @(posedge clock);
         #1;
         if (!reset) begin
            axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
         end else begin
            axi_arready = rnd_mode ? coin() : 1'b1;
            if (!(axi_rvalid && !hs_r)) axi_rvalid = (r_owed > 0) && (rnd_mode ? coin() : 1'b1);
            axi_rdata   = cur_line[r_beat*64 +: 64];
            axi_rlast   = (r_beat == 3) || (r_beat == rlast_bad);
            axi_rresp   = 2'b00;
            axi_awready = rnd_mode ? coin() : (aw_wait >= aw_delay);
            axi_wready  = rnd_mode ? coin() : 1'b1;
            if (!(axi_bvalid && !hs_b)) axi_bvalid = b_pend && (rnd_mode ? coin() : 1'b1);
            axi_bresp   = bresp_inj;
         end
      end
   end

   logic [255:0] exp_q[$];

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [255:0] line,
                         input bit hold_gap, output int lat);
      logic [255:0] exp;
      @(posedge clock);
      #1;
      cur_addr = addr & 32'hFFFF_FFE0;
      cur_line = line;
      exp_q.push_back(we ? 256'd0 : line);
      mem_req_valid = 1'b1;
      mem_req_we    = we;
      mem_req_addr  = addr;
      mem_req_data  = we ? line : ~line;
      lat = 0;
      forever begin
         @(negedge clock);
         if (mem_resp_valid) break;
         lat++;
         if (lat > 400) break;
      end
      exp = exp_q.pop_front();
      if (!mem_resp_valid) chk("resp_timeout", 1'b0, 1'b1);
      else chk(we ? "wr_resp_data" : "rd_resp_data", mem_resp_data, exp);
      t_resp = cyc;
      @(posedge clock);
      #1;
      if (!hold_gap) mem_req_valid = 1'b0;
      @(negedge clock);
      chk("resp_one_pulse", mem_resp_valid, 1'b0);
      if (hold_gap) begin
         @(posedge clock);
         #1;
         mem_req_valid = 1'b0;
      end
   endtask

   initial begin
      int lat, ar0, r0, n;
      bit we;
      n_run = 0; n_fail = 0;
      rnd_mode = 0; aw_delay = 0; rlast_bad = -1; bresp_inj = 2'b00;
      cur_line = '0; cur_addr = '0;
      reset = 1'b0; mem_req_valid = 0; mem_req_we = 0; mem_req_addr = '0; mem_req_data = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_resp", {mem_resp_valid, mem_resp_data}, 257'd0);
      chk("rst_valids", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready}, 6'd0);
      chk("rst_bus_err", bus_err, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // zero-wait read
      do_req(1'b0, 32'h0000_1234,
             {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 1'b0, lat);
      chk("rd_latency", lat, 6);
      chk("rd_bus_err", bus_err, 1'b0);

      // write with AW held off: W burst finishes first, resp the cycle after B
      aw_delay = 5;
      do_req(1'b1, 32'h0000_8040,
             {64'hDEAD_0123_4567_89AB, 64'h1111_2222_3333_4444,
              64'h5555_6666_7777_8888, 64'hCAFE_F00D_0000_BEEF}, 1'b0, lat);
      chk("w_before_aw", t_w3 < t_aw, 1'b1);
      chk("resp_after_b", t_resp - t_b, 1);
      aw_delay = 0;

      do_req(1'b1, 32'h1234_5678, rand_line(), 1'b0, lat);
      chk("wr_latency", lat, 6);

      // request held through GAP must not start another burst
      ar0 = ar_cnt;
      do_req(1'b0, 32'h0000_2000, rand_line(), 1'b1, lat);
      repeat (4) @(negedge clock);
      chk("gap_no_rerun", ar_cnt, ar0 + 1);

      rnd_mode = 1;
      for (n = 0; n < 200; n++) begin
         we = coin();
         do_req(we, $urandom, rand_line(), 1'b0, lat);
      end
      rnd_mode = 0;
      chk("rand_bus_err", bus_err, 1'b0);

      bresp_inj = 2'b10;
      do_req(1'b1, 32'h0000_3000, rand_line(), 1'b0, lat);
      chk("bresp_err", bus_err, 1'b1);
      bresp_inj = 2'b00;

      // reset while the read is on its third beat
      @(posedge clock);
      #1;
      cur_line = rand_line();
      cur_addr = 32'h0000_4000;
      mem_req_valid = 1'b1; mem_req_we = 1'b0; mem_req_addr = 32'h0000_4000; mem_req_data = '0;
      n = 0;
      while (r_beat != 2 && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("rst_reach_beat2", r_beat, 2);
      @(posedge clock);
      #1;
      reset = 1'b0;
      mem_req_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("midrst_valids", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 5'd0);
      chk("midrst_resp", mem_resp_valid, 1'b0);
      chk("midrst_bus_err", bus_err, 1'b0);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         chk("midrst_no_resp", mem_resp_valid, 1'b0);
      end

      rlast_bad = 1;
      r0 = r_total;
      do_req(1'b0, 32'h0000_5000, rand_line(), 1'b0, lat);
      chk("rlast_beats", r_total - r0, 4);
      chk("rlast_err", bus_err, 1'b1);
      rlast_bad = -1;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

Converts the cached CPU's single-outstanding 256-bit line memory interface into AXI4 master bursts: 4 beats × 64 bits, INCR. Sits directly downstream of the cached CPU top, on its `mem_req_*`/`mem_resp_*` port, and directly upstream of the DRAM controller or interconnect. Handles one line transaction at a time. Reports AXI error responses and beat-count protocol faults on a sticky flag.

## Interface
- `LINE_W`, 256: line width in bits. Fixed to 4 × `AXI_DW`.
- `AXI_DW`, 64: AXI data width in bits.
- `AXI_ID`, 0: constant ARID/AWID, 4 bits wide.
- `clock`  input  1  sole clock. All logic is on its rising edge.
- `reset`  input  1  synchronous, active-low reset (asserted when 0).
- `mem_req_valid`  input  1  line request present.
- `mem_req_addr`  input  32  byte address. Bits [4:0] are ignored.
- `mem_req_we`  input  1  1 = line write-back, 0 = line fill.
- `mem_req_data`  input  256  write line.
- `mem_resp_valid`  output  1  one-cycle completion pulse, for reads and writes.
- `mem_resp_data`  output  256  fill line. 0 for writes.
- `axi_ar*`, `axi_r*`, `axi_aw*`, `axi_w*`, `axi_b*`  AXI4 master channels.
  - Fields: id 4, addr 32, len 8, size 3, burst 2, data 64, strb 8, resp 2, last 1, plus valid/ready.
- `bus_err`  output  1  sticky error flag. Cleared only by reset.

## Operation
- **Requester contract**
  - Requester holds `mem_req_valid` and payload stable until it samples `mem_resp_valid`=1.
  - Requester drops `mem_req_valid` in the following cycle.
- **States:** IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_BRESP, RESP, GAP.
- **IDLE**
  - On `mem_req_valid`=1, latch address, we and data.
  - Go to RD_ADDR if we=0, else WR_ADDR.
- **Fixed AXI fields**
  - addr = {req_addr[31:5], 5'b0}.
  - len = 3, size = 3'b011, burst = INCR (2'b01), id = `AXI_ID`.
  - wstrb = 8'hFF.
- **RD_ADDR**
  - `arvalid`=1 until `arready`, then go to RD_DATA.
- **RD_DATA**
  - `rready`=1.
  - Beat k (2-bit counter) is written to line bits [64k+63:64k].
  - After the 4th handshake, go to RESP.
- **WR_ADDR** (AW and W run concurrently)
  - `awvalid` is held until its handshake; an aw_done flag records completion.
  - `wvalid` is held through beats 0..3, with `wdata` = line slice k and `wlast` on k=3.
  - Leave for WR_BRESP when aw_done is set and the beat-3 W handshake has occurred. Either order is allowed, including the same cycle.
- **WR_BRESP**
  - `bready`=1. On `bvalid`, go to RESP.
- **RESP**
  - `mem_resp_valid`=1 for exactly one cycle, then go to GAP.
- **GAP**
  - `mem_req_valid` is ignored for one cycle, then go to IDLE.
  - This prevents a stale request being re-accepted.
- **`bus_err` set conditions**
  - rresp ≠ 0 on any beat.
  - bresp ≠ 0.
  - rlast=1 on beats 0–2.
  - rlast=0 on beat 3.
- **Error handling:** transactions still complete normally and always return 4 beats of data. No retry.

## Timing
- All outputs are registered.
- **Reset values:** `mem_resp_valid`=0, `mem_resp_data`=0, every AXI valid/ready=0, `wlast`=0, `bus_err`=0, state=IDLE, beat counter=0.
- **Read latency**
  - AR is presented 1 cycle after the accept cycle.
  - `mem_resp_valid` rises the cycle after the 4th R handshake.
  - With zero-wait AXI: accept at t, ARVALID at t+1, R beats at t+2..t+5, response at t+6.
- **Write latency**
  - With zero-wait AXI: AW and W0 at t+1, W3 at t+4, BRESP at t+5, response at t+6.
- **Back-to-back:** earliest next accept is 2 cycles after the `mem_resp_valid` cycle (RESP, then GAP, then IDLE).
- **Stalls:** valid signals never drop before their handshake. Payload is stable while valid and not ready.
- **Reset mid-burst:** reset returns the block to IDLE immediately. The AXI slave is reset with the bridge; no drain is attempted.

## Structure
- Package `mem_axi_pkg` holds:
  - state enum `mab_state_e`;
  - `BEATS`=4, `AXSIZE_8B`=3'b011, `BURST_INCR`=2'b01, `RESP_OKAY`=2'b00.
- Single module. No sub-module: the beat counter and line slicing are inline.

## Test plan
- **Read, zero-wait:** read of 0x0000_1234 with R beats 0x11..,0x22..,0x33..,0x44.. -> ARADDR=0x0000_1220, ARLEN=3; `mem_resp_data`={0x44..,0x33..,0x22..,0x11..}; response at t+6; `bus_err`=0.
- **Write with delayed AW:** write of line 0xDEAD…BEEF with AWREADY delayed 5 cycles and WREADY=1 -> all W beats complete first; WLAST only on beat 3; response pulses once, the cycle after BVALID.
- **Random backpressure:** random ready/valid stalls on all channels -> payload stable while stalled; data matches the reference line over 200 transactions.
- **Error flags:** BRESP=2'b10 -> transaction completes and `bus_err` latches 1. Separately, rlast on beat 1 -> `bus_err`=1 and 4 beats are still consumed.
- **Back-to-back with reset:** requester keeps `mem_req_valid`=1 during the GAP cycle -> no second AR issued. Reset asserted during RD_DATA beat 2 -> next cycle all AXI valids=0 and `mem_resp_valid` stays 0.
